// File: rtl/booth_mac_sequencer.sv
// -----------------------------------------------------------------------------
// booth_mac_sequencer
//
// Purpose:
//   Sits between an operand source and the 8x8 signed Booth multiplier
//   (booth_multiplication). Each accepted operand pair is issued to the
//   multiplier. When the product is ready it is sign-extended and added into a
//   signed accumulator. The pair flagged in_last closes the sequence: the
//   accumulated dot product is presented on acc_out with a one-cycle
//   acc_valid pulse, and the accumulator restarts from zero.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   in_valid     in   1      operand pair valid
//   in_ready     out  1      sequencer can accept a pair (IDLE only)
//   in_a         in   8      signed multiplicand
//   in_b         in   8      signed multiplier
//   in_last      in   1      pair is the final one of the current sequence
//   mul_a        out  8      operand a to the multiplier (held while issued)
//   mul_b        out  8      operand b to the multiplier (held while issued)
//   mul_start    out  1      start request to the multiplier
//   mul_busy     in   1      multiplier busy
//   mul_ab       in   16     signed product from the multiplier
//   acc_out      out  ACC_W  accumulated result, held between results
//   acc_valid    out  1      one-cycle pulse, acc_out carries a new result
//   overflow     out  1      sticky for the current sequence, accumulator wrapped
//   timeout_err  out  1      one-cycle pulse, the multiplier never went busy
//
// Parameters:
//   ACC_W         accumulator/result width (signed, >= 16)
//   BUSY_TIMEOUT  cycles spent in ISSUE waiting for mul_busy before the pair
//                 is abandoned
// -----------------------------------------------------------------------------
module booth_mac_sequencer #(
   parameter int ACC_W        = 24,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic             in_last,
   output logic [7:0]       mul_a,
   output logic [7:0]       mul_b,
   output logic             mul_start,
   input  logic             mul_busy,
   input  logic [15:0]      mul_ab,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   output logic             overflow,
   output logic             timeout_err
);

   // Timer only has to reach BUSY_TIMEOUT-1; keep at least one bit.
   localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_ACC   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t                   r_state;
   logic [7:0]               r_mul_a;
   logic [7:0]               r_mul_b;
   logic                     r_last;
   logic signed [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]         r_acc_out;
   logic                     r_overflow;
   logic                     r_timeout_err;
   logic [TMR_W-1:0]         r_timer;
   // High until the first pair of a sequence has been accepted; that
   // acceptance is what clears the sticky overflow of the previous sequence.
   logic                     r_new_seq;

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   state_t                   w_next;
   logic                     w_in_ready;
   logic                     w_mul_start;
   logic                     w_acc_valid;
   logic                     w_fire;
   logic                     w_timeout;
   logic                     w_timer_exp;
   logic signed [ACC_W-1:0]  w_ext;
   logic signed [ACC_W-1:0]  w_sum;
   logic                     w_add_ovf;

   // Handshake: a pair moves from the source into the sequencer on a rising
   // edge where in_valid=1 and in_ready=1. in_ready is asserted only in IDLE
   // and does not depend on in_valid. A source holding in_valid high while
   // in_ready is low keeps its pair; nothing is sampled outside IDLE.
   assign w_fire = (r_state == S_IDLE) && in_valid;

   // ISSUE lasts at most BUSY_TIMEOUT cycles: the timer reads 0 in the first
   // ISSUE cycle and BUSY_TIMEOUT-1 in the last one.
   assign w_timer_exp = (r_timer == TMR_W'(BUSY_TIMEOUT - 1));

   // Products span -16256..+16384, so the 16-bit value must be sign-extended
   // before it joins the wider accumulator.
   assign w_ext = ACC_W'($signed(mul_ab));
   assign w_sum = r_acc + w_ext;

   // Two's-complement add overflows only when both addends share a sign and
   // the wrapped sum does not.
   assign w_add_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

   // ---------------------------------------------------------------------------
   // Next-state and Moore outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_mul_start = 1'b0;
      w_acc_valid = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_mul_start = 1'b1;
            if (mul_busy) begin
               // Also covers a multiplier that is already busy on entry.
               w_next = S_WAIT;
            end else if (w_timer_exp) begin
               // Pair abandoned: no accumulate, its last flag is ignored.
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!mul_busy) begin
               w_next = S_ACC;
            end
         end
         S_ACC: begin
            w_next = r_last ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            w_acc_valid = 1'b1;
            w_next      = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_mul_a       <= 8'd0;
         r_mul_b       <= 8'd0;
         r_last        <= 1'b0;
         r_acc         <= '0;
         r_acc_out     <= '0;
         r_overflow    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_timer       <= '0;
         r_new_seq     <= 1'b1;
      end else begin
         r_state       <= w_next;
         r_timeout_err <= w_timeout;

         // Operands and last flag are captured only at the transfer and then
         // held, so the multiplier sees stable inputs for the whole pair.
         if (w_fire) begin
            r_mul_a <= in_a;
            r_mul_b <= in_b;
            r_last  <= in_last;
            if (r_new_seq) begin
               r_overflow <= 1'b0;
               r_new_seq  <= 1'b0;
            end
         end

         if (r_state == S_ISSUE) begin
            r_timer <= r_timer + 1'b1;
         end else begin
            r_timer <= '0;
         end

         if (r_state == S_ACC) begin
            r_acc <= w_sum;
            if (w_add_ovf) begin
               r_overflow <= 1'b1;
            end
            // Loading the result here lets acc_out and acc_valid line up in
            // the DONE cycle; acc_out then holds until the next result.
            if (r_last) begin
               r_acc_out <= w_sum;
            end
         end

         if (r_state == S_DONE) begin
            r_acc     <= '0;
            r_new_seq <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready    = w_in_ready;
   assign mul_start   = w_mul_start;
   assign mul_a       = r_mul_a;
   assign mul_b       = r_mul_b;
   assign acc_out     = r_acc_out;
   assign acc_valid   = w_acc_valid;
   assign overflow    = r_overflow;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_booth_mac_sequencer
//
// Two sequencers share clock and reset: dut0 with the default 24-bit
// accumulator and dut1 with a 16-bit accumulator for wrap behaviour. A
// behavioural multiplier answers each mul_start after a programmable delay.
// Expected results come from a dot-product model (plain integer arithmetic
// wrapped to the accumulator width) fed from the operands the bench sends.
// -----------------------------------------------------------------------------
module tb_booth_mac_sequencer;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // DUT signals (index 0 -> dut0, index 1 -> dut1)
   // ---------------------------------------------------------------------------
   logic [1:0]  in_valid;
   logic [1:0]  in_last;
   logic [7:0]  in_a [2];
   logic [7:0]  in_b [2];
   logic [1:0]  mul_busy = 2'b00;
   logic [15:0] mul_ab [2];
   wire  [1:0]  in_ready;
   wire  [1:0]  mul_start;
   wire  [1:0]  acc_valid;
   wire  [1:0]  overflow;
   wire  [1:0]  timeout_err;
   wire  [7:0]  mul_a [2];
   wire  [7:0]  mul_b [2];
   wire  [23:0] acc_out0;
   wire  [15:0] acc_out1;
   longint      acc_s [2];

   booth_mac_sequencer #(.ACC_W(24), .BUSY_TIMEOUT(64)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]),
      .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_start(mul_start[0]),
      .mul_busy(mul_busy[0]), .mul_ab(mul_ab[0]),
      .acc_out(acc_out0), .acc_valid(acc_valid[0]),
      .overflow(overflow[0]), .timeout_err(timeout_err[0])
   );

   booth_mac_sequencer #(.ACC_W(16), .BUSY_TIMEOUT(64)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]),
      .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_start(mul_start[1]),
      .mul_busy(mul_busy[1]), .mul_ab(mul_ab[1]),
      .acc_out(acc_out1), .acc_valid(acc_valid[1]),
      .overflow(overflow[1]), .timeout_err(timeout_err[1])
   );

   always_comb begin
      acc_s[0] = longint'($signed(acc_out0));
      acc_s[1] = longint'($signed(acc_out1));
   end

   // ---------------------------------------------------------------------------
   // Counters, model state, scoreboard
   // ---------------------------------------------------------------------------
   int          total = 0;
   int          bad   = 0;

   logic [63:0] exp_q [2][$];
   logic [0:0]  ovf_q [2][$];
   longint      m_acc [2];
   bit          m_ovf [2];
   bit          new_seq [2];
   int          accw [2];

   int          n_valid [2];
   int          n_tmo [2];
   int          start_run [2];
   int          last_run [2];
   longint      last_acc [2];
   logic        last_ovf [2];
   logic        prev_valid [2];
   logic [7:0]  last_a [2];
   logic [7:0]  last_b [2];

   // Multiplier model knobs
   bit          never_busy [2];
   bit          rnd [2];
   int          busy_dly [2];
   int          busy_len [2];
   int          mm_phase [2];
   int          mm_cnt [2];
   int          mm_len [2];
   logic [15:0] mm_prod [2];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic longint wrap(input longint v, input int w);
      longint m;
      longint r;
      m = longint'(1) << w;
      r = v & (m - 1);
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

   // Dot-product model: every accepted pair opens or continues a sequence;
   // dropped pairs contribute nothing and their last flag is ignored.
   task automatic model_accept(input int k, input logic [7:0] a, input logic [7:0] b,
                               input bit last, input bit drop);
      longint p;
      longint s;
      longint w;
      if (new_seq[k]) begin
         m_ovf[k]   = 1'b0;
         new_seq[k] = 1'b0;
      end
      if (!drop) begin
         p = longint'($signed(a)) * longint'($signed(b));
         s = m_acc[k] + p;
         w = wrap(s, accw[k]);
         if (w != s) m_ovf[k] = 1'b1;
         m_acc[k] = w;
         if (last) begin
            exp_q[k].push_back(64'(w));
            ovf_q[k].push_back(m_ovf[k]);
            m_acc[k]   = 0;
            new_seq[k] = 1'b1;
         end
      end
   endtask

   task automatic model_clear(input int k);
      exp_q[k].delete();
      ovf_q[k].delete();
      m_acc[k]   = 0;
      m_ovf[k]   = 1'b0;
      new_seq[k] = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural multiplier: after mul_start is seen, wait busy_dly cycles,
   // hold busy for busy_len cycles with junk on mul_ab, then present a*b.
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mm_phase[k] == 0) begin
            if (mul_start[k] && !never_busy[k]) begin
               mm_prod[k]  = 16'(longint'($signed(mul_a[k])) * longint'($signed(mul_b[k])));
               mm_len[k]   = rnd[k] ? int'($urandom_range(1, 5)) : busy_len[k];
               mm_cnt[k]   = rnd[k] ? int'($urandom_range(0, 3)) : busy_dly[k];
               mm_phase[k] = 1;
            end
         end
         if (mm_phase[k] == 1) begin
            if (mm_cnt[k] == 0) begin
               mul_busy[k] = 1'b1;
               mul_ab[k]   = 16'($urandom);
               mm_cnt[k]   = mm_len[k];
               mm_phase[k] = 2;
            end else begin
               mm_cnt[k]--;
            end
         end else if (mm_phase[k] == 2) begin
            mm_cnt[k]--;
            if (mm_cnt[k] <= 0) begin
               mul_busy[k] = 1'b0;
               mul_ab[k]   = mm_prod[k];
               mm_phase[k] = 0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Compare process: results against the scoreboard, plus per-cycle
   // handshake/operand checks while a pair is being issued.
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin : p_cmp
      logic [63:0] e;
      logic [0:0]  o;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            if (acc_valid[k]) begin
               check("acc_valid_single_cycle", longint'(prev_valid[k]), 0);
               n_valid[k]++;
               last_acc[k] = acc_s[k];
               last_ovf[k] = overflow[k];
               if (exp_q[k].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL acc_valid_unexpected: dut%0d acc_out=%0d required no pulse", k, acc_s[k]);
               end else begin
                  e = exp_q[k].pop_front();
                  o = ovf_q[k].pop_front();
                  check("acc_out", acc_s[k], longint'($signed(e)));
                  check("overflow_at_result", longint'(overflow[k]), longint'(o));
               end
            end
            prev_valid[k] = acc_valid[k];
            if (mul_start[k]) begin
               check("ready_low_while_issuing", longint'(in_ready[k]), 0);
               check("mul_a_stable", longint'(mul_a[k]), longint'(last_a[k]));
               check("mul_b_stable", longint'(mul_b[k]), longint'(last_b[k]));
               start_run[k]++;
            end else if (start_run[k] != 0) begin
               last_run[k]  = start_run[k];
               start_run[k] = 0;
            end
            if (timeout_err[k]) n_tmo[k]++;
         end else begin
            prev_valid[k] = 1'b0;
            start_run[k]  = 0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (called at a falling edge)
   // ---------------------------------------------------------------------------
   // hold=1 keeps in_valid high and scrambles the operands until in_ready
   // returns; the caller must send the next pair straight away.
   task automatic send(input int k, input int a, input int b, input bit last,
                       input bit drop, input bit hold);
      int t;
      in_valid[k] = 1'b1;
      in_a[k]     = 8'(a);
      in_b[k]     = 8'(b);
      in_last[k]  = last;
      t = 0;
      while (in_ready[k] !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (in_ready[k] !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL send_accept: dut%0d in_ready=%0b required 1", k, in_ready[k]);
         in_valid[k] = 1'b0;
         return;
      end
      last_a[k] = 8'(a);
      last_b[k] = 8'(b);
      model_accept(k, 8'(a), 8'(b), last, drop);
      @(negedge clk);
      check("ready_low_after_transfer", longint'(in_ready[k]), 0);
      if (hold) begin
         t = 0;
         while (in_ready[k] !== 1'b1 && t < 400) begin
            in_a[k]    = 8'($urandom);
            in_b[k]    = 8'($urandom);
            in_last[k] = 1'($urandom);
            @(negedge clk);
            t++;
         end
      end else begin
         in_valid[k] = 1'b0;
      end
   endtask

   task automatic wait_valid(input int k, input int nv);
      int t;
      t = 0;
      while (n_valid[k] == nv && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (n_valid[k] == nv) begin
         total++;
         bad++;
         $display("FAIL wait_acc_valid: dut%0d no result within 300 cycles, count=%0d required %0d",
                  k, n_valid[k], nv + 1);
      end
   endtask

   task automatic check_reset_values(input int k, input string tag);
      check({tag, "_in_ready"},    longint'(in_ready[k]), 1);
      check({tag, "_mul_start"},   longint'(mul_start[k]), 0);
      check({tag, "_mul_a"},       longint'(mul_a[k]), 0);
      check({tag, "_mul_b"},       longint'(mul_b[k]), 0);
      check({tag, "_acc_out"},     acc_s[k], 0);
      check({tag, "_acc_valid"},   longint'(acc_valid[k]), 0);
      check({tag, "_overflow"},    longint'(overflow[k]), 0);
      check({tag, "_timeout_err"}, longint'(timeout_err[k]), 0);
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin : p_main
      int nv;
      int nt;
      int t;
      int len;
      bit hold;
      accw[0] = 24;
      accw[1] = 16;
      for (int k = 0; k < 2; k++) begin
         in_valid[k]   = 1'b0;
         in_last[k]    = 1'b0;
         in_a[k]       = 8'd0;
         in_b[k]       = 8'd0;
         mul_ab[k]     = 16'd0;
         never_busy[k] = 1'b0;
         rnd[k]        = 1'b0;
         busy_dly[k]   = 1;
         busy_len[k]   = 2;
         new_seq[k]    = 1'b1;
      end

      // Reset state
      #1 rst = 1'b1;
      #1;
      check_reset_values(0, "reset0");
      check_reset_values(1, "reset1");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single-pair sequence; mul_start held through a 3-cycle busy delay
      busy_dly[0] = 3;
      nv = n_valid[0];
      send(0, 5, 10, 1'b1, 1'b0, 1'b0);
      wait_valid(0, nv);
      check("single_pair_acc", last_acc[0], 50);
      check("single_pair_ovf", longint'(last_ovf[0]), 0);
      check("start_held_cycles", longint'(last_run[0]), 4);

      // Two-pair sequence with a negative product
      busy_dly[0] = 1;
      nv = n_valid[0];
      send(0, 5, 10, 1'b0, 1'b0, 1'b0);
      send(0, 8, -7, 1'b1, 1'b0, 1'b0);
      wait_valid(0, nv);
      check("two_pair_acc", last_acc[0], -6);
      check("two_pair_raw", longint'(acc_out0), 64'h0000_0000_00FF_FFFA);
      repeat (3) @(negedge clk);
      check("two_pair_one_pulse", longint'(n_valid[0]), longint'(nv + 1));

      // 16-bit accumulator wraps on the second of four 16384 products
      nv = n_valid[1];
      for (int i = 0; i < 4; i++) begin
         send(1, -128, -128, (i == 3), 1'b0, 1'b0);
      end
      wait_valid(1, nv);
      check("wrap16_acc", last_acc[1], 0);
      check("wrap16_ovf", longint'(last_ovf[1]), 1);
      repeat (3) @(negedge clk);
      check("wrap16_ovf_held", longint'(overflow[1]), 1);
      nv = n_valid[1];
      send(1, 1, 1, 1'b1, 1'b0, 1'b0);
      check("wrap16_ovf_cleared", longint'(overflow[1]), 0);
      wait_valid(1, nv);
      check("wrap16_next_acc", last_acc[1], 1);

      // Multiplier never goes busy: pair dropped after 64 ISSUE cycles
      never_busy[0] = 1'b1;
      nt = n_tmo[0];
      nv = n_valid[0];
      send(0, 7, 7, 1'b1, 1'b1, 1'b0);
      t = 0;
      while (n_tmo[0] == nt && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check("timeout_pulse_count", longint'(n_tmo[0]), longint'(nt + 1));
      check("timeout_issue_cycles", longint'(last_run[0]), 64);
      check("timeout_ready", longint'(in_ready[0]), 1);
      repeat (3) @(negedge clk);
      check("timeout_single_pulse", longint'(n_tmo[0]), longint'(nt + 1));
      check("timeout_no_result", longint'(n_valid[0]), longint'(nv));
      never_busy[0] = 1'b0;
      send(0, 3, 3, 1'b1, 1'b0, 1'b0);
      wait_valid(0, nv);
      check("after_timeout_acc", last_acc[0], 9);

      // Asynchronous reset while the second pair is in WAIT
      busy_dly[0] = 0;
      busy_len[0] = 8;
      send(0, 2, 2, 1'b0, 1'b0, 1'b0);
      send(0, 3, 3, 1'b1, 1'b0, 1'b0);
      t = 0;
      while (!(mul_start[0] == 1'b0 && mul_busy[0] == 1'b1) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("reached_wait_before_reset", longint'(mul_busy[0] && !mul_start[0]), 1);
      #2 rst = 1'b1;
      #1;
      check_reset_values(0, "midreset");
      model_clear(0);
      model_clear(1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      busy_len[0] = 2;
      nv = n_valid[0];
      send(0, 1, -1, 1'b1, 1'b0, 1'b0);
      wait_valid(0, nv);
      check("after_reset_acc", last_acc[0], -1);

      // Back-to-back pairs with in_valid held and operands scrambled meanwhile
      nv = n_valid[0];
      send(0, 10, 20, 1'b0, 1'b0, 1'b1);
      send(0, -3, 4, 1'b0, 1'b0, 1'b1);
      send(0, 100, -100, 1'b1, 1'b0, 1'b0);
      wait_valid(0, nv);
      check("held_valid_acc", last_acc[0], -9812);

      // Randomized sequences against the model
      rnd[0] = 1'b1;
      for (int s = 0; s < 30; s++) begin
         len = int'($urandom_range(1, 4));
         for (int i = 0; i < len; i++) begin
            hold = !(s == 29 && i == len - 1) && ($urandom_range(0, 1) == 1);
            send(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 (i == len - 1), 1'b0, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      t = 0;
      while (exp_q[0].size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check("drain_dut0", longint'(exp_q[0].size()), 0);
      check("drain_dut1", longint'(exp_q[1].size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/booth_mac_sequencer.md
Name: booth_mac_sequencer

Overview:
- Upstream/downstream wrapper around the 8x8 signed Booth multiplier (`booth_multiplication`).
- Accepts a stream of signed 8-bit operand pairs over a valid/ready handshake. For each pair it drives the multiplier, waits for the product, and accumulates it into a signed accumulator.
- Emits the dot-product result when the pair flagged `in_last` has been accumulated.
- Sits between the operand source and the multiplier, and owns the multiplier's start/busy protocol.

Parameters:
- ACC_W, 24, accumulator/result width in bits, signed, must be >= 16.
- BUSY_TIMEOUT, 64, max cycles to wait for `mul_busy` to rise after `mul_start` before aborting the pair.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  8  signed multiplicand.
- in_b  in  8  signed multiplier.
- in_last  in  1  pair is the final one of the current sequence.
- mul_a  out  8  operand a to the multiplier.
- mul_b  out  8  operand b to the multiplier.
- mul_start  out  1  start request to the multiplier.
- mul_busy  in  1  multiplier busy.
- mul_ab  in  16  signed product from the multiplier.
- acc_out  out  ACC_W  accumulated result.
- acc_valid  out  1  one-cycle pulse; `acc_out` is valid.
- overflow  out  1  sticky for the current sequence; accumulator wrapped.
- timeout_err  out  1  one-cycle pulse; the multiplier never went busy.

Behaviour:
- Reset (async, rst=1): state=IDLE; `in_ready`=1; `mul_start`=0; `mul_a`=`mul_b`=0; accumulator=0; `acc_out`=0; `acc_valid`=0; `overflow`=0; `timeout_err`=0; last-flag register=0.
- Reset mid-operation: the same values apply immediately. The in-flight pair and partial sum are discarded.
- Handshake: a transfer occurs on a rising edge with `in_valid`=1 and `in_ready`=1. `in_ready`=1 only in IDLE.
- FSM:
  - IDLE: on transfer, register `in_a`/`in_b`/`in_last` into `mul_a`/`mul_b`/last, go to ISSUE.
  - ISSUE: `mul_start`=1, `mul_a`/`mul_b` held stable.
    - Stay until `mul_busy`=1 is sampled, then go to WAIT.
    - If `mul_busy` is still 0 after BUSY_TIMEOUT cycles in ISSUE: pulse `timeout_err`, drop the pair (no accumulate, last-flag ignored), go to IDLE.
  - WAIT: `mul_start`=0. Stay while `mul_busy`=1. On the first sampled `mul_busy`=0, go to ACC.
  - ACC (one cycle): accumulator += sign-extend(`mul_ab`) to ACC_W, two's-complement wrap.
    - Signed overflow of that add sets `overflow`.
    - If last-flag=1, go to DONE; else go to IDLE.
  - DONE (one cycle): `acc_out`<=accumulator, `acc_valid`=1. The accumulator clears to 0. Go to IDLE.
  - `overflow` clears on the first accepted pair of the next sequence, so it remains readable alongside `acc_out` until then.
- Per-pair latency: 1 (IDLE->ISSUE) + ISSUE cycles + busy duration + 1 (ACC). Plus 1 (DONE) for the last pair. `acc_valid` is high for exactly 1 cycle.
- `acc_out` holds its value between DONE events.
- Operands are sampled only at transfer. Input changes at other times have no effect.
- Single-pair sequence (`in_last` on the first pair) is legal: result = that product.
- Products range from -16256 to +16384. Sign extension is mandatory (e.g. 8 * -7 = 0xFFC8 -> -56).
- `mul_busy` already 1 on entering ISSUE: go to WAIT on the next edge.
- `in_valid` held high in non-IDLE states: no transfer, and the pair is not lost at the source.

Test Plan:
- Pairs (5,10,last) -> `mul_start` held until `mul_busy` rises; `acc_valid` pulse with `acc_out`=50, `overflow`=0.
- Sequence (5,10),(8,-7,last) -> `acc_out`=-6 (0xFFFFFA), one `acc_valid` pulse, `in_ready` low from each transfer until IDLE.
- 4 x (-128,-128), with ACC_W=16 override and last on the 4th pair -> first add OK (16384), second wraps; `overflow`=1 through DONE. The next sequence's first transfer clears `overflow`.
- Multiplier model never raises `mul_busy` -> `timeout_err` pulse after 64 ISSUE cycles, no `acc_valid`, back to IDLE with `in_ready`=1. The next pair (3,3,last) gives `acc_out`=9.
- Assert `rst` during WAIT of the second pair of (2,2),(3,3,last) -> all outputs at reset values asynchronously. A new (1,-1,last) after release gives `acc_out`=-1.
- `in_valid` held high with changing `in_a` during WAIT -> only the IDLE-sampled operands are used. Back-to-back pairs with zero gap give a correct running sum.
